// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared segment types and the active-low 7-segment code table
// for the hex display scanner (segment bit0 = a .. bit6 = g, 0 = lit).
package hex_display_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Entry n is the glyph for nibble n; listed F down to 0 so index 0 lands at the LSBs.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if: processor-side load bus plus static and scanned display
// outputs. With HEX_DISPLAY_BLINK_EN defined the Blink request is carried too.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                      Load;
    logic [4*NUM_DIGITS-1:0]   Value;
    logic [NUM_DIGITS-1:0]     Dp_in;
    logic                      Lz_en;
`ifdef HEX_DISPLAY_BLINK_EN
    logic                      Blink;
`endif
    logic [7*NUM_DIGITS-1:0]   Seg_all;
    logic [6:0]                Seg;
    logic                      Dp;
    logic [NUM_DIGITS-1:0]     Digit_en;
    logic [IDX_W-1:0]          Scan_idx;

    modport master (
        output Load, Value, Dp_in, Lz_en,
`ifdef HEX_DISPLAY_BLINK_EN
        output Blink,
`endif
        input  Seg_all, Seg, Dp, Digit_en, Scan_idx
    );

    modport slave (
        input  Load, Value, Dp_in, Lz_en,
`ifdef HEX_DISPLAY_BLINK_EN
        input  Blink,
`endif
        output Seg_all, Seg, Dp, Digit_en, Scan_idx
    );

endinterface

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: pure combinational nibble to active-low 7-segment glyph.
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: latches an N-nibble value and drives it both as registered
// static per-digit segments and as a time-multiplexed scan bus with one-cold digit
// enables. Leading-zero suppression is applied live; decimal points are latched.
// Optional macro HEX_DISPLAY_BLINK_EN adds a Blink input that darkens the segment
// outputs during the upper half of a 24-bit free-running counter period.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int PRESCALE   = 50000,
    localparam int CNT_W      = $clog2(PRESCALE)
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    hex_display_scanner_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0][3:0]       shadow_val;
    logic [NUM_DIGITS-1:0]            shadow_dp;
    logic [NUM_DIGITS-1:0]            zero_hi;
    logic [NUM_DIGITS-1:0]            blank;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] digit_dec;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] digit_seg;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_all_r;
    seg_t                             scan_dec;
    seg_t                             scan_seg;
    seg_t                             seg_r;
    logic                             dp_r;
    logic [NUM_DIGITS-1:0]            den_r;
    logic [CNT_W-1:0]                 cnt;
    logic                             wrap;
    logic [IDX_W-1:0]                 idx;
    logic [IDX_W-1:0]                 idx_nxt;
    logic                             dark;

    // Shadow registers: capture value and decimal points on Load, hold otherwise.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (bus.Load) begin
            shadow_val <= bus.Value;
            shadow_dp  <= bus.Dp_in;
        end
    end

    // Leading-zero mask: zero_hi[k] means nibbles k..top are all zero; digit 0 never blanks.
    always_comb begin
        zero_hi = '0;
        blank   = '0;
        zero_hi[NUM_DIGITS-1] = (shadow_val[NUM_DIGITS-1] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--)
            zero_hi[k] = zero_hi[k+1] && (shadow_val[k] == 4'h0);
        for (int k = 1; k < NUM_DIGITS; k++)
            blank[k] = bus.Lz_en && zero_hi[k];
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        hex_seg_decode u_dec (
            .nib (shadow_val[k]),
            .seg (digit_dec[k])
        );
        assign digit_seg[k] = blank[k] ? SEG_BLANK : digit_dec[k];
    end

    // Scan bus is decoded for the digit that will be selected after this edge, so
    // segments, dp and enable always move together.
    hex_seg_decode u_scan_dec (
        .nib (shadow_val[idx_nxt]),
        .seg (scan_dec)
    );
    assign scan_seg = blank[idx_nxt] ? SEG_BLANK : scan_dec;

    assign wrap = (cnt == CNT_W'(PRESCALE - 1));

    // Next scan slot: advance only on prescale wrap, wrapping after the top digit.
    always_comb begin
        idx_nxt = idx;
        if (wrap)
            idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end

    // Prescale counter and scan index.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            idx <= idx_nxt;
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    logic [23:0] blink_cnt;
    logic [23:0] blink_nxt;

    assign blink_nxt = blink_cnt + 24'd1;
    // Dark decision uses the counter's next value so the dark window tracks its MSB exactly.
    assign dark = bus.Blink && blink_nxt[23];

    // Free-running blink timebase.
    always_ff @(posedge Clock) begin
        if (!Resetn) blink_cnt <= '0;
        else         blink_cnt <= blink_nxt;
    end
`else
    assign dark = 1'b0;
`endif

    // Registered display outputs, all dark in reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            seg_all_r <= '1;
            seg_r     <= SEG_BLANK;
            dp_r      <= 1'b1;
            den_r     <= '1;
        end else begin
            seg_all_r <= dark ? '1 : digit_seg;
            seg_r     <= dark ? SEG_BLANK : scan_seg;
            dp_r      <= dark | ~shadow_dp[idx_nxt];
            den_r     <= ~(NUM_DIGITS'(1) << idx_nxt);
        end
    end

    assign bus.Seg_all  = seg_all_r;
    assign bus.Seg      = seg_r;
    assign bus.Dp       = dp_r;
    assign bus.Digit_en = den_r;
    assign bus.Scan_idx = idx;

endmodule
